// File: rtl/nonce_tx_framer.sv
// nonce_tx_framer
//   Buffers golden nonces from the hashing core in a small FIFO and serialises each one
//   into a 6-byte UART frame: SYNC, nonce[31:24], [23:16], [15:8], [7:0], XOR checksum.
//   Bytes are paced on the UART's is_transmitting handshake, with GUARD idle cycles
//   after every byte. New frames are not started while the UART is receiving.
// Ports
//   clock, reset           : uart clock; asynchronous active-low reset
//   nonce_we, nonce_in     : push strobe and nonce value
//   clear_overflow         : clears the sticky overflow flag
//   is_transmitting        : uart transmitter busy
//   is_receiving           : uart receiver busy (gates frame start only)
//   txce, tx               : one-cycle send strobe and byte (tx holds between strobes)
//   busy                   : frame in progress
//   fifo_count             : FIFO occupancy
//   overflow               : sticky, a push was dropped on a full FIFO
//   frames_sent            : completed frame counter (wraps)
// GUARD must be at least 1.
module nonce_tx_framer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter int unsigned GUARD      = 2,
    localparam int unsigned PW        = $clog2(FIFO_DEPTH),
    localparam int unsigned CW        = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          nonce_we,
    input  logic [31:0]   nonce_in,
    input  logic          clear_overflow,
    input  logic          is_transmitting,
    input  logic          is_receiving,
    output logic          txce,
    output logic [7:0]    tx,
    output logic          busy,
    output logic [CW-1:0] fifo_count,
    output logic          overflow,
    output logic [15:0]   frames_sent
);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StLoad     = 3'd1;
    localparam logic [2:0] StSend     = 3'd2;
    localparam logic [2:0] StWaitBusy = 3'd3;
    localparam logic [2:0] StWaitDone = 3'd4;
    localparam logic [2:0] StGap      = 3'd5;

    localparam logic [CW-1:0] DepthC    = CW'(FIFO_DEPTH);
    localparam logic [7:0]    GuardLast = 8'(GUARD - 1);

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   frames_q, frames_d;
    logic [2:0]    state_q, state_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    gap_q, gap_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    send_byte;
    logic          pop, push_ok;

    always_comb begin
        case (idx_q)
            3'd0:    send_byte = SYNC_BYTE;
            3'd1:    send_byte = shadow_q[31:24];
            3'd2:    send_byte = shadow_q[23:16];
            3'd3:    send_byte = shadow_q[15:8];
            3'd4:    send_byte = shadow_q[7:0];
            3'd5:    send_byte = csum_q;
            default: send_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        csum_d   = csum_q;
        gap_d    = gap_q;
        tx_d     = tx_q;
        frames_d = frames_q;
        pop      = 1'b0;
        case (state_q)
            StIdle: begin
                if (count_q != '0 && !is_receiving) begin
                    pop      = 1'b1;
                    shadow_d = mem_q[rd_ptr_q];
                    idx_d    = 3'd0;
                    csum_d   = 8'h00;
                    state_d  = StLoad;
                end
            end
            StLoad: state_d = StSend;
            StSend: begin
                tx_d = send_byte;
                // Only the four nonce bytes feed the checksum.
                if (idx_q != 3'd0 && idx_q != 3'd5) csum_d = csum_q ^ send_byte;
                state_d = StWaitBusy;
            end
            StWaitBusy: if (is_transmitting) state_d = StWaitDone;
            StWaitDone: begin
                if (!is_transmitting) begin
                    gap_d   = 8'd0;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_q == GuardLast) begin
                    if (idx_q == 3'd5) begin
                        frames_d = frames_q + 16'd1;
                        state_d  = StIdle;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StSend;
                    end
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A pop in the same cycle frees the slot, so a push to a full FIFO is still taken.
    always_comb begin
        push_ok = nonce_we && (count_q != DepthC || pop);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (nonce_we && !push_ok)  overflow_d = 1'b1;
        else if (clear_overflow)   overflow_d = 1'b0;
        else                       overflow_d = overflow_q;
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= nonce_in;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            frames_q   <= 16'h0000;
            state_q    <= StIdle;
            shadow_q   <= 32'h0;
            idx_q      <= 3'd0;
            csum_q     <= 8'h00;
            gap_q      <= 8'h00;
            tx_q       <= 8'h00;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q    <= count_d;
            overflow_q <= overflow_d;
            frames_q   <= frames_d;
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            gap_q      <= gap_d;
            tx_q       <= tx_d;
        end
    end

    // tx shows the new byte during the SEND cycle itself, then holds it.
    assign txce        = (state_q == StSend);
    assign tx          = (state_q == StSend) ? send_byte : tx_q;
    assign busy        = (state_q != StIdle);
    assign fifo_count  = count_q;
    assign overflow    = overflow_q;
    assign frames_sent = frames_q;

endmodule
